mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Y86-64 memory stage. It sits between execute and pc_update/writeback, and produces valM for pc_update (ret) and for register writeback (mrmovq, popq).
- Owns a byte-addressed little-endian data memory and moves one byte per clock, so every memory access takes 8 cycles.
- A valid/ready handshake toward execute stalls the upstream stage while an access is in flight.

Parameters:
- MEM_BYTES, 256, data memory size in bytes; legal byte addresses are 0..MEM_BYTES-1.
- ADDR_W, 64, width of the address operands (valE, valA).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  stage can accept; high only in IDLE.
- icode  in  4  instruction code from execute.
- valE  in  64  ALU result; address for rmmovq/mrmovq/pushq/call.
- valA  in  64  store data for rmmovq/pushq; address for popq/ret.
- valP  in  64  return address, stored by call.
- out_valid  out  1  one-cycle pulse; result fields are valid while it is high.
- out_icode  out  4  icode of the completed instruction.
- out_valE  out  64  valE passed through.
- valM  out  64  loaded value; 0 for non-load instructions.
- dmem_error  out  1  access address out of range; qualified by out_valid.
- busy  out  1  access in progress; equals the inverse of in_ready.

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, out_icode=0, out_valE=0, valM=0, dmem_error=0, byte counter=0. Memory array contents are not cleared.
- Accept happens on an edge with in_valid && in_ready. The stage latches icode, the address, store data and the operation class.
- Operation classes:
  - Read, address=valE: icode 5 (mrmovq).
  - Read, address=valA: icode 9 (ret) and B (popq).
  - Write valA to address valE: icode 4 (rmmovq) and A (pushq).
  - Write valP to address valE: icode 8 (call).
  - All other icodes are non-memory.
- Range check at accept: error if addr > MEM_BYTES-8, using an unsigned 64-bit compare with no wrap. On error, no memory access is performed; state goes to DONE and dmem_error=1.
- FSM states:
  - IDLE: accept → READ, WRITE or DONE. Non-memory and error cases go directly to DONE.
  - READ: each edge loads mem[addr+k] into valM bits [8k+7:8k], for k=0..7. Edge k=7 → DONE.
  - WRITE: each edge writes data bits [8k+7:8k] to mem[addr+k]. Edge k=7 → DONE.
  - DONE: out_valid=1 for exactly one cycle, then → IDLE. in_ready stays 0 during DONE.
- Latency from the accept edge to out_valid high:
  - 1 cycle for non-memory and error cases.
  - 9 cycles for loads and stores (8 byte cycles plus DONE).
- valM is cleared to 0 at accept and holds its value after DONE until the next accept. Stores and non-memory instructions leave valM=0.
- Throughput: one instruction per (latency+1) cycles; there is no back-to-back accept.
- Store data is captured at accept, so upstream may change valA/valE/valP after the accept edge.
- Reset asserted mid-WRITE: bytes already written stay written and the remaining bytes are not written. This is the documented behaviour, not an error.
- icode 0 (halt) is passed through as a non-memory instruction with out_icode=0.
- The stage ignores in_valid while busy.

Decomposition:
- Shared package y86_defs holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - The FSM state enum (IDLE, READ, WRITE, DONE).
- One sub-module, data_mem_byte: MEM_BYTES x 8 array with a single synchronous write port and a combinational read port. It has no reset.
- The FSM, byte counter and range check stay in mem_stage.

Test Plan:
- rmmovq store: icode=4, valE=0x40, valA=0x1122334455667788. Expect in_ready low for 9 cycles, out_valid at accept+9, and mem[0x40..0x47]=88,77,66,55,44,33,22,11.
- mrmovq load: icode=5, valE=0x40 after the store above. Expect valM=0x1122334455667788, out_valid at accept+9, dmem_error=0.
- Stack ops:
  - call: icode=8, valE=0x78, valP=0x2A. Then ret: icode=9, valA=0x78. Expect ret valM=0x2A.
  - popq: icode=B, valA=0x78. Expect valM=0x2A.
- Non-memory: icode=6, valE=0x5. Expect out_valid at accept+1, valM=0, out_valE=0x5, and the next accept possible at accept+2.
- Range error: mrmovq with valE=0xF9 (MEM_BYTES=256). Expect dmem_error=1 at accept+1, memory untouched. Repeat with valE=0xF8: dmem_error=0.
- Reset mid-store: assert reset after 3 WRITE edges of a store of 0xFFFFFFFFFFFFFFFF to address 0x10 (mem[0x10..0x17] previously 0). Expect outputs zero and in_ready=1 immediately, mem[0x10..0x12]=FF, mem[0x13..0x17]=00.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared Y86-64 definitions: instruction codes and the memory-stage FSM states.
package y86_defs;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_stage_data_mem_byte.sv
// Byte-wide data memory: one synchronous write port, combinational read.
// No reset: contents survive a stage reset.
module data_mem_byte #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Single write port; read and write share the address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: one byte per clock, 8-cycle loads/stores, valid/ready
// handshake toward execute, one-cycle out_valid pulse on completion.
module mem_stage
  import y86_defs::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valE,
  input  logic [ADDR_W-1:0] valA,
  input  logic [ADDR_W-1:0] valP,
  output logic              out_valid,
  output logic [3:0]        out_icode,
  output logic [ADDR_W-1:0] out_valE,
  output logic [63:0]       valM,
  output logic              dmem_error,
  output logic              busy
);

  localparam int MA = $clog2(MEM_BYTES);
  // Highest legal base address of an 8-byte access.
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES - 8);

  mem_state_t        state, state_d;
  logic [2:0]        cnt;
  logic [MA-1:0]     addr_q;
  logic [63:0]       data_q;

  logic              op_rd, op_wr, range_err, accept;
  logic [ADDR_W-1:0] addr_sel, data_sel;
  logic [MA-1:0]     mem_addr;
  logic [7:0]        mem_rdata, mem_wdata;
  logic              mem_we;

  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Classify the incoming instruction and pick its address and store data.
  always_comb begin
    op_rd    = 1'b0;
    op_wr    = 1'b0;
    addr_sel = valE;
    data_sel = valA;
    case (icode)
      IMRMOVQ:        op_rd = 1'b1;
      IRET, IPOPQ:    begin op_rd = 1'b1; addr_sel = valA; end
      IRMMOVQ, IPUSHQ: op_wr = 1'b1;
      ICALL:          begin op_wr = 1'b1; data_sel = valP; end
      default: ;
    endcase
  end

  // Unsigned full-width compare, so huge addresses cannot wrap into range.
  assign range_err = (op_rd | op_wr) && (addr_sel > LIMIT);

  // Next-state logic; non-memory and out-of-range accesses skip straight to DONE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (range_err || !(op_rd || op_wr)) state_d = DONE;
          else if (op_rd)                     state_d = READ;
          else                                state_d = WRITE;
        end
      end
      READ, WRITE: if (cnt == 3'd7) state_d = DONE;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Capture operands at accept, then step through the bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      out_icode  <= '0;
      out_valE   <= '0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else if (accept) begin
      cnt        <= '0;
      addr_q     <= addr_sel[MA-1:0];
      data_q     <= 64'(data_sel);
      out_icode  <= icode;
      out_valE   <= valE;
      valM       <= '0;
      dmem_error <= range_err;
    end else if (state == READ) begin
      valM[{cnt, 3'b000} +: 8] <= mem_rdata;
      cnt <= cnt + 3'd1;
    end else if (state == WRITE) begin
      cnt <= cnt + 3'd1;
    end
  end

  // Base address was range-checked at accept, so this add never wraps.
  assign mem_addr  = addr_q + MA'(cnt);
  assign mem_we    = (state == WRITE);
  assign mem_wdata = data_q[{cnt, 3'b000} +: 8];

  data_mem_byte #(
    .DEPTH(MEM_BYTES),
    .AW   (MA)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads, stack ops, range errors,
// non-memory pass-through and reset during a store.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        out_valid;
  logic [3:0]  out_icode;
  logic [63:0] out_valE;
  logic [63:0] valM;
  logic        dmem_error;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.MEM_BYTES(256), .ADDR_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .valE      (valE),
    .valA      (valA),
    .valP      (valP),
    .out_valid (out_valid),
    .out_icode (out_icode),
    .out_valE  (out_valE),
    .valM      (valM),
    .dmem_error(dmem_error),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction, accept it, then count cycles until out_valid.
  // Leaves the bench sampling on the negedge where out_valid is high.
  task automatic issue(input string tag, input logic [3:0] ic, input logic [63:0] e,
                       input logic [63:0] a, input logic [63:0] p, input int exp_lat);
    int lat = 0;
    int nrdy = 0;
    int bad_busy = 0;
    @(negedge clk);
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    icode = ic; valE = e; valA = a; valP = p; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    // Scramble operands: captured values must have been latched at accept.
    valE = ~e; valA = ~a; valP = ~p; icode = 4'h6;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (!in_ready) nrdy++;
      if (busy !== !in_ready) bad_busy++;
      if (out_valid) break;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_notready"}, 64'(nrdy), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(bad_busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_err", {63'd0, dmem_error}, 64'd0);
    chk("rst_icode", {60'd0, out_icode}, 64'd0);
    chk("rst_valE", out_valE, 64'd0);
    @(negedge clk) reset = 1'b0;

    // Zero 0x38..0x3F, then store at 0x40.
    issue("clr38", 4'h4, 64'h38, 64'h0, 64'h0, 9);
    issue("st40", 4'h4, 64'h40, 64'h1122334455667788, 64'h0, 9);
    chk("st40_valM", valM, 64'd0);
    chk("st40_icode", {60'd0, out_icode}, 64'h4);
    chk("st40_err", {63'd0, dmem_error}, 64'd0);

    issue("ld40", 4'h5, 64'h40, 64'h0, 64'h0, 9);
    chk("ld40_valM", valM, 64'h1122334455667788);
    chk("ld40_err", {63'd0, dmem_error}, 64'd0);
    chk("ld40_icode", {60'd0, out_icode}, 64'h5);
    repeat (2) @(negedge clk);
    chk("ld40_hold", valM, 64'h1122334455667788);

    // Straddling load proves little-endian byte order.
    issue("ld3c", 4'h5, 64'h3C, 64'h0, 64'h0, 9);
    chk("ld3c_valM", valM, 64'h5566778800000000);

    // Stack ops.
    issue("call", 4'h8, 64'h78, 64'h0, 64'h2A, 9);
    chk("call_valM", valM, 64'd0);
    issue("ret", 4'h9, 64'h0, 64'h78, 64'h0, 9);
    chk("ret_valM", valM, 64'h2A);
    chk("ret_icode", {60'd0, out_icode}, 64'h9);
    issue("pop", 4'hB, 64'h80, 64'h78, 64'h0, 9);
    chk("pop_valM", valM, 64'h2A);
    chk("pop_valE", out_valE, 64'h80);
    issue("push", 4'hA, 64'h70, 64'hCAFE_F00D_0000_0001, 64'h0, 9);
    issue("ld70", 4'h5, 64'h70, 64'h0, 64'h0, 9);
    chk("ld70_valM", valM, 64'hCAFE_F00D_0000_0001);

    // Non-memory, then an immediate back-to-back accept at accept+2.
    issue("opq", 4'h6, 64'h5, 64'h0, 64'h0, 1);
    chk("opq_valM", valM, 64'd0);
    chk("opq_valE", out_valE, 64'h5);
    chk("opq_err", {63'd0, dmem_error}, 64'd0);
    issue("irm", 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1);
    chk("irm_valE", out_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("irm_err", {63'd0, dmem_error}, 64'd0);
    issue("halt", 4'h0, 64'h9, 64'h0, 64'h0, 1);
    chk("halt_icode", {60'd0, out_icode}, 64'h0);

    // Range boundary.
    issue("st_f8", 4'h4, 64'hF8, 64'h0102030405060708, 64'h0, 9);
    issue("rng_f9", 4'h5, 64'hF9, 64'h0, 64'h0, 1);
    chk("rng_f9_err", {63'd0, dmem_error}, 64'd1);
    chk("rng_f9_valM", valM, 64'd0);
    issue("wr_f9", 4'h4, 64'hF9, 64'hDEAD, 64'h0, 1);
    chk("wr_f9_err", {63'd0, dmem_error}, 64'd1);
    issue("rng_f8", 4'h5, 64'hF8, 64'h0, 64'h0, 9);
    chk("rng_f8_err", {63'd0, dmem_error}, 64'd0);
    chk("rng_f8_valM", valM, 64'h0102030405060708);
    issue("rng_huge", 4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 1);
    chk("rng_huge_err", {63'd0, dmem_error}, 64'd1);
    issue("pop_100", 4'hB, 64'h0, 64'h100, 64'h0, 1);
    chk("pop_100_err", {63'd0, dmem_error}, 64'd1);

    // Reset after three write edges of a store to 0x10.
    issue("clr10", 4'h4, 64'h10, 64'h0, 64'h0, 9);
    @(negedge clk);
    icode = 4'h4; valE = 64'h10; valA = 64'hFFFF_FFFF_FFFF_FFFF; valP = '0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_icode", {60'd0, out_icode}, 64'd0);
    chk("mid_valE", out_valE, 64'd0);
    chk("mid_valM", valM, 64'd0);
    @(negedge clk) reset = 1'b0;
    issue("ld10", 4'h5, 64'h10, 64'h0, 64'h0, 9);
    chk("ld10_valM", valM, 64'h0000_0000_00FF_FFFF);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
